// File: rtl/im_stream_fetcher_pkg.sv
// im_stream_fetcher_pkg: shared FSM state type and memory-word geometry helpers for the stream fetchers.
package im_stream_fetcher_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_e;
  localparam int unsigned BitsPerByte = 8;
  localparam int unsigned MemBytesPerWord = 64 / BitsPerByte;
  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / BitsPerByte;
  endfunction
  function automatic int unsigned words_per_hv(input int unsigned hv_dim, input int unsigned data_width);
    return hv_dim / data_width;
  endfunction
endpackage

// File: rtl/im_word_assembler.sv
// im_word_assembler: collects memory words into one item and flags when that item is complete.
module im_word_assembler
  import im_stream_fetcher_pkg::*;
#(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned MemDataWidth = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    highdim_i,
  input  logic                    word_valid_i,
  input  logic [MemDataWidth-1:0] word_i,
  input  logic                    take_i,
  output logic [HVDimension-1:0]  item_o,
  output logic                    complete_o
);
  localparam int unsigned WordsPerHv = words_per_hv(HVDimension, MemDataWidth);
  localparam int unsigned CntWidth = WordsPerHv > 1 ? $clog2(WordsPerHv) : 1;
  logic [HVDimension-1:0] asm_q, asm_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, last;
  // The incoming word is bypassed into item_o so a finished item can load the output register the same cycle.
  always_comb begin
    last = !highdim_i || cnt_q == CntWidth'(WordsPerHv - 1);
    asm_d = asm_q;
    if (word_valid_i) asm_d[cnt_q*MemDataWidth +: MemDataWidth] = word_i;
    complete_o = pend_q || (word_valid_i && last);
    cnt_d = word_valid_i ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    pend_d = complete_o && !take_i;
    if (clr_i) begin
      asm_d = '0;
      cnt_d = '0;
      pend_d = 1'b0;
    end
  end
  assign item_o = asm_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      asm_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: rtl/im_stream_fetcher.sv
// im_stream_fetcher: streams a contiguous run of items from data memory into one item-memory input port.
module im_stream_fetcher
  import im_stream_fetcher_pkg::*;
#(
  parameter int unsigned HVDimension   = 512,
  parameter int unsigned ImAddrWidth   = 10,
  parameter int unsigned MemDataWidth  = 64,
  parameter int unsigned MemAddrWidth  = 32,
  parameter int unsigned NumItemsWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     start_i,
  input  logic [MemAddrWidth-1:0]  base_addr_i,
  input  logic [NumItemsWidth-1:0] num_items_i,
  input  logic                     highdim_mode_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     mem_req_o,
  output logic [MemAddrWidth-1:0]  mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [MemDataWidth-1:0]  mem_rdata_i,
  output logic [ImAddrWidth-1:0]   lowdim_data_o,
  output logic [HVDimension-1:0]   highdim_data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i
);
  localparam logic [MemAddrWidth-1:0] AddrStep = MemAddrWidth'(bytes_per_word(MemDataWidth));
  fetch_state_e state_q, state_d;
  logic [MemAddrWidth-1:0] ptr_q, ptr_d;
  logic [NumItemsWidth-1:0] num_q, num_d, cnt_q, cnt_d, cnt_inc;
  logic hd_q, hd_d, busy_q, busy_d, done_q, done_d, outst_q, outst_d, valid_q, valid_d;
  logic [ImAddrWidth-1:0] low_q, low_d;
  logic [HVDimension-1:0] high_q, high_d, item;
  logic start, hs, gnt, word_valid, complete, take, all_fetched;

  assign start = start_i && !clr_i && state_q == IDLE && !busy_q;
  assign hs = valid_q && data_ready_i;
  assign gnt = state_q == REQ && mem_gnt_i;
  assign word_valid = state_q == WAIT && outst_q && mem_rvalid_i;
  assign all_fetched = cnt_q == num_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign take = state_q == WAIT && complete && (!valid_q || data_ready_i) && !clr_i;

  im_word_assembler #(
    .HVDimension (HVDimension),
    .MemDataWidth(MemDataWidth)
  ) u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .highdim_i   (hd_q),
    .word_valid_i(word_valid),
    .word_i      (mem_rdata_i),
    .take_i      (take),
    .item_o      (item),
    .complete_o  (complete)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q <= '0;
      num_q <= '0;
      cnt_q <= '0;
      hd_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      outst_q <= 1'b0;
      valid_q <= 1'b0;
      low_q <= '0;
      high_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      num_q <= num_d;
      cnt_q <= cnt_d;
      hd_q <= hd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      outst_q <= outst_d;
      valid_q <= valid_d;
      low_q <= low_d;
      high_q <= high_d;
    end
  end

  // A clear with a read in flight parks in DRAIN so the late rvalid is swallowed.
  always_comb begin
    case (state_q)
      IDLE:    state_d = (start && num_items_i != '0) ? REQ : IDLE;
      REQ:     state_d = mem_gnt_i ? WAIT : REQ;
      WAIT:    state_d = all_fetched ? (hs ? IDLE : WAIT)
                       : ((word_valid && !complete) || (take && cnt_inc != num_q)) ? REQ : WAIT;
      default: state_d = mem_rvalid_i ? IDLE : DRAIN;
    endcase
    if (clr_i)
      state_d = ((state_q == WAIT && outst_q && !mem_rvalid_i) || gnt
                 || (state_q == DRAIN && !mem_rvalid_i)) ? DRAIN : IDLE;
    ptr_d = start ? base_addr_i : gnt ? ptr_q + AddrStep : ptr_q;
    num_d = start ? num_items_i : num_q;
    hd_d = start ? highdim_mode_i : hd_q;
    outst_d = clr_i ? 1'b0 : gnt ? 1'b1 : mem_rvalid_i ? 1'b0 : outst_q;
    cnt_d = (clr_i || start) ? '0 : take ? cnt_inc : cnt_q;
    valid_d = clr_i ? 1'b0 : take ? 1'b1 : hs ? 1'b0 : valid_q;
    low_d = clr_i ? '0 : take ? (hd_q ? '0 : item[ImAddrWidth-1:0]) : low_q;
    high_d = clr_i ? '0 : take ? (hd_q ? item : '0) : high_q;
    done_d = !clr_i && ((start && num_items_i == '0) || (state_q == WAIT && all_fetched && hs));
    busy_d = clr_i ? 1'b0 : start ? 1'b1 : (state_q == IDLE || done_d) ? 1'b0 : busy_q;
  end

  always_comb begin
    busy_o = busy_q;
    done_o = done_q;
    mem_req_o = state_q == REQ;
    mem_addr_o = ptr_q;
    data_valid_o = valid_q;
    lowdim_data_o = low_q;
    highdim_data_o = high_q;
  end
endmodule

// File: tb/tb_im_stream_fetcher.sv
// tb_im_stream_fetcher: randomized scoreboard bench for im_stream_fetcher against a memory-image item model.
module tb_im_stream_fetcher;
  typedef struct packed {
    logic [9:0]   lo;
    logic [511:0] hi;
  } item_t;

  logic clk_i = 1'b0;
  logic rst_i, clr_i, start_i, highdim_mode_i, mem_gnt_i, mem_rvalid_i, data_ready_i;
  logic [31:0] base_addr_i;
  logic [15:0] num_items_i;
  logic [63:0] mem_rdata_i;
  logic busy_o, done_o, mem_req_o, data_valid_o;
  logic [31:0] mem_addr_o;
  logic [9:0] lowdim_data_o;
  logic [511:0] highdim_data_o;

  always #5 clk_i = ~clk_i;

  im_stream_fetcher #(
    .HVDimension(512), .ImAddrWidth(10), .MemDataWidth(64), .MemAddrWidth(32), .NumItemsWidth(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_items_i(num_items_i), .highdim_mode_i(highdim_mode_i),
    .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .lowdim_data_o(lowdim_data_o), .highdim_data_o(highdim_data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, req_count = 0, done_cnt = 0, done_base = 0, last_hs_cyc = -10;
  int gnt_pct = 100, lat_min = 1, lat_max = 1, ready_pct = 100;
  bit ready_rand = 0, zero_xfer = 0;
  logic [63:0] salt = 64'h0123_4567_89ab_cdef;
  logic [63:0] mem_img [logic [31:0]];
  logic [31:0] req_addrs[$];
  item_t exp_q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_read(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a ^ salt[31:0], (a * 32'h9E37_79B9) ^ salt[63:32]};
  endfunction

  // Item i of a run occupies the i-th group of words (1 or 8) after the base address.
  task automatic push_expected(input logic [31:0] base, input int n, input logic hd);
    item_t it;
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      it = '0;
      if (hd) for (int k = 0; k < 8; k++) it.hi[k*64 +: 64] = mem_read(base + 32'((i * 8 + k) * 8));
      else begin
        w = mem_read(base + 32'(i * 8));
        it.lo = w[9:0];
      end
      exp_q.push_back(it);
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input int n, input logic hd);
    @(negedge clk_i);
    push_expected(base, n, hd);
    done_base = done_cnt;
    base_addr_i = base;
    num_items_i = 16'(n);
    highdim_mode_i = hd;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #2;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done_cnt == done_base; i++) begin
      @(negedge clk_i);
      #2;
    end
    chk("done_pulses", 512'(done_cnt - done_base), 1);
    chk("scoreboard_empty", 512'(exp_q.size()), 0);
  endtask

  task automatic wait_reqs(input int k);
    for (int i = 0; i < 200 && req_count < k; i++) begin
      @(negedge clk_i);
      #2;
    end
    chk("req_reached", 512'(req_count), 512'(k));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_valid"}, data_valid_o, 0);
    chk({tag, "_lowdim"}, lowdim_data_o, 0);
    chk({tag, "_highdim"}, highdim_data_o, 0);
  endtask

  // Memory: grants with a configurable probability, returns data lat_min..lat_max cycles after the grant.
  initial begin
    int pend;
    logic [31:0] paddr;
    pend = 0;
    paddr = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = mem_read(paddr);
        end
      end
      mem_gnt_i = mem_req_o && pend == 0 && ($urandom_range(0, 99) < gnt_pct);
      if (mem_gnt_i) begin
        req_count++;
        req_addrs.push_back(mem_addr_o);
        paddr = mem_addr_o;
        pend = $urandom_range(lat_min, lat_max);
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (ready_rand) data_ready_i = ($urandom_range(0, 99) < ready_pct);
  end

  // Monitor: pops the scoreboard on each output handshake and checks handshake/request stability.
  initial begin
    logic pv, pr, pcr, preq, pgnt;
    logic [9:0] plo;
    logic [511:0] phi;
    logic [31:0] paddr;
    item_t e;
    pv = 0; pr = 0; pcr = 1; preq = 0; pgnt = 0; plo = '0; phi = '0; paddr = '0;
    forever begin
      @(negedge clk_i);
      #1;
      cyc++;
      if (!rst_i) begin
        if (pv && !pr && !pcr) begin
          chk("hold_valid", data_valid_o, 1);
          chk("hold_lowdim", lowdim_data_o, plo);
          chk("hold_highdim", highdim_data_o, phi);
        end
        if (preq && !pgnt && !pcr) begin
          chk("req_hold", mem_req_o, 1);
          chk("addr_hold", mem_addr_o, paddr);
        end
        if (data_valid_o && data_ready_i && !clr_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_item: got lowdim %0h, expected no item", lowdim_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("item_lowdim", lowdim_data_o, e.lo);
            chk("item_highdim", highdim_data_o, e.hi);
            if (exp_q.size() == 0) last_hs_cyc = cyc;
          end
        end
        if (done_o) begin
          done_cnt++;
          if (!zero_xfer) begin
            chk("done_after_last_hs", 512'(cyc), 512'(last_hs_cyc + 1));
            chk("busy_at_done", busy_o, 0);
          end
        end
      end
      pv = data_valid_o; pr = data_ready_i; pcr = rst_i | clr_i;
      preq = mem_req_o; pgnt = mem_gnt_i; paddr = mem_addr_o;
      plo = lowdim_data_o; phi = highdim_data_o;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; clr_i = 0; start_i = 0; base_addr_i = '0; num_items_i = '0;
    highdim_mode_i = 0; data_ready_i = 1;
    repeat (3) @(negedge clk_i);
    #2;
    chk_zero_outputs("reset");
    @(negedge clk_i);
    rst_i = 0;

    // Low-dim run of 3 with a fixed memory image and a 3-cycle first-item latency.
    mem_img[32'h100] = 64'd5; mem_img[32'h108] = 64'd7; mem_img[32'h110] = 64'd9;
    req_addrs.delete();
    req_count = 0;
    start_xfer(32'h100, 3, 1'b0);
    @(negedge clk_i); #2;
    chk("latency_cycle2_valid", data_valid_o, 0);
    @(negedge clk_i); #2;
    chk("latency_cycle3_valid", data_valid_o, 1);
    chk("latency_cycle3_lowdim", lowdim_data_o, 5);
    wait_done(200);
    chk("lowdim_req_count", 512'(req_addrs.size()), 3);
    for (int i = 0; i < 3 && i < req_addrs.size(); i++) chk("lowdim_addr_seq", req_addrs[i], 32'h100 + 32'(8 * i));

    // High-dim single item, words k+1.
    for (int k = 0; k < 8; k++) mem_img[32'h2000 + 32'(8 * k)] = 64'(k + 1);
    req_count = 0;
    start_xfer(32'h2000, 1, 1'b1);
    wait_done(400);
    chk("highdim_req_count", 512'(req_count), 8);

    // Backpressure: consumer stalls, at most one extra item is fetched.
    data_ready_i = 0;
    req_count = 0;
    start_xfer(32'h300, 4, 1'b0);
    repeat (12) @(negedge clk_i);
    #2;
    chk("bp_req_count", 512'(req_count), 2);
    chk("bp_no_req", mem_req_o, 0);
    chk("bp_valid_held", data_valid_o, 1);
    @(negedge clk_i);
    data_ready_i = 1;
    @(negedge clk_i); #2;
    chk("bp_no_bubble", data_valid_o, 1);
    wait_done(400);

    // Zero-item transfer.
    zero_xfer = 1;
    req_count = 0;
    start_xfer(32'h500, 0, 1'b0);
    chk("zero_done_c1", done_o, 1);
    chk("zero_busy_c1", busy_o, 1);
    @(negedge clk_i); #2;
    chk("zero_done_c2", done_o, 0);
    chk("zero_busy_c2", busy_o, 0);
    chk("zero_req_count", 512'(req_count), 0);
    zero_xfer = 0;

    // Clear while a read is outstanding; the late word must be dropped.
    lat_min = 3; lat_max = 3;
    req_count = 0;
    start_xfer(32'h400, 2, 1'b0);
    wait_reqs(1);
    @(negedge clk_i);
    clr_i = 1;
    exp_q.delete();
    done_base = done_cnt;
    @(negedge clk_i);
    clr_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #2;
      chk("clr_valid_low", data_valid_o, 0);
    end
    chk("clr_no_done", 512'(done_cnt - done_base), 0);
    chk("clr_busy_low", busy_o, 0);
    chk("clr_no_more_req", 512'(req_count), 1);
    lat_min = 1; lat_max = 1;
    start_xfer(32'h480, 2, 1'b0);
    wait_done(200);

    // Reset in the middle of a high-dim item, then restart from a new base.
    req_count = 0;
    start_xfer(32'h800, 1, 1'b1);
    wait_reqs(5);
    @(negedge clk_i);
    rst_i = 1;
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 0;
    #2;
    chk_zero_outputs("midrst");
    repeat (4) @(negedge clk_i);
    for (int k = 0; k < 8; k++) mem_img[32'h900 + 32'(8 * k)] = {32'hA5A5_0000 + 32'(k), 32'(k * 3)};
    start_xfer(32'h900, 1, 1'b1);
    wait_done(400);

    // Randomized runs.
    ready_rand = 1;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] b;
      salt = {$urandom, $urandom};
      gnt_pct = $urandom_range(30, 100);
      lat_min = 1;
      lat_max = $urandom_range(1, 3);
      ready_pct = $urandom_range(30, 100);
      b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom;
      start_xfer(b, $urandom_range(1, 5), 1'($urandom_range(0, 1)));
      wait_done(3000);
    end
    ready_rand = 0;
    data_ready_i = 1;
    repeat (3) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/im_stream_fetcher.md
Name: im_stream_fetcher

Overview:
- Producer-side streamer that feeds one item-memory input port: the lowdim/highdim data plus the valid/ready handshake.
- Reads a contiguous run of items from the data memory over a req/gnt/rvalid port.
- Assembles each item into either a low-dim address or a full hypervector.
- Presents items one at a time with valid/ready. Two instances serve port A and port B.

Parameters:
- HVDimension, 512, hypervector width in bits.
- ImAddrWidth, 10, width of the low-dim item-memory address.
- MemDataWidth, 64, memory read data width; HVDimension must be a multiple of it.
- MemAddrWidth, 32, byte address width.
- NumItemsWidth, 16, width of the item-count register.
- WordsPerHv, HVDimension/MemDataWidth, derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clr_i  in  1  synchronous soft clear
- start_i  in  1  one-cycle pulse; latches the configuration and begins
- base_addr_i  in  MemAddrWidth  byte address of the first word
- num_items_i  in  NumItemsWidth  number of items to stream
- highdim_mode_i  in  1  0: one word per item (low-dim); 1: WordsPerHv words per item
- busy_o  out  1  a transfer is in progress
- done_o  out  1  one-cycle pulse after the last item handshakes
- mem_req_o  out  1  read request
- mem_addr_o  out  MemAddrWidth  read byte address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  MemDataWidth  read data
- lowdim_data_o  out  ImAddrWidth  low-dim item (mem_rdata_i[ImAddrWidth-1:0])
- highdim_data_o  out  HVDimension  assembled hypervector
- data_valid_o  out  1  output item valid
- data_ready_i  in  1  consumer ready

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FSM goes to IDLE.
  - All counters are cleared.
  - All outputs go to 0: busy_o, done_o, mem_req_o, mem_addr_o, data_valid_o, lowdim_data_o, highdim_data_o.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - On start_i: latch base_addr_i, num_items_i and highdim_mode_i; set the address pointer to base_addr_i; busy_o=1.
  - If num_items_i==0: go straight to done (done_o=1 next cycle, busy_o back to 0); no memory requests are issued.
  - Otherwise go to REQ.
  - start_i while busy is ignored.
- REQ:
  - mem_req_o=1 and mem_addr_o=pointer, both held stable until mem_gnt_i.
  - On gnt: pointer += MemDataWidth/8; go to WAIT.
  - At most one read is outstanding.
- WAIT: on mem_rvalid_i, store the word.
  - Low-dim mode: the word is the item.
  - High-dim mode: word k (k=0..WordsPerHv-1) lands in assembly bits [k*MemDataWidth +: MemDataWidth]; the word counter wraps to 0 after WordsPerHv-1.
- Item complete, output register empty or handshaking this cycle:
  - Item moves to the output register; data_valid_o=1 on the next cycle.
  - Item counter increments.
  - If more items remain, go to REQ.
- Item complete, output register full and not draining: hold in WAIT (no new requests) until the transfer happens. This gives one item of buffering (assembly + output), so a new fetch overlaps consumption of the previous item.
- Output handshake:
  - Transfer when data_valid_o && data_ready_i.
  - data_valid_o, lowdim_data_o and highdim_data_o stay stable while valid and not ready.
  - In low-dim mode highdim_data_o holds 0; in high-dim mode lowdim_data_o holds 0.
- Completion: once the last item has been fetched and its output handshake occurs:
  - done_o=1 for one cycle, in the cycle after the handshake.
  - busy_o falls in that same cycle.
- Simultaneous handshake and new item:
  - Handshake and the load of a new item into the output register in the same cycle is legal.
  - data_valid_o stays 1 with the new data and there is no bubble.
- clr_i:
  - Drops data_valid_o and clears counters and the assembly buffer.
  - In IDLE or REQ (before gnt): go to IDLE at once; mem_req_o deasserts.
  - In WAIT with a read outstanding: go to DRAIN, discard the next mem_rvalid_i, then go to IDLE.
  - No done_o pulse is generated on clear.
- rst_i takes priority over clr_i, and clr_i over start_i.
- Address arithmetic is unsigned and wraps modulo 2^MemAddrWidth.
- Latency, low-dim, idle consumer, single-cycle gnt and rvalid one cycle after gnt: start_i at cycle 0 → req at cycle 1 → gnt cycle 1 → rvalid cycle 2 → data_valid_o cycle 3.

Decomposition:
- Shared package (hypercorex-wide): FSM state enum, and a localparam for bytes per memory word.
- One sub-module, im_word_assembler: word counter, shift-in assembly register, and complete flag, with a per-mode word count.
- FSM, pointer, item counter and the output register stay in the top.

Test Plan:
- Low-dim mode, base 0x100, num_items 3, memory returns 5, 7, 9, consumer always ready:
  - mem_addr_o sequence is 0x100, 0x108, 0x110.
  - lowdim_data_o sequence is 5, 7, 9.
  - done_o pulses once; the start-to-first-valid latency is 3.
- High-dim mode, WordsPerHv=8, words 0..7 = k+1, num_items 1:
  - highdim_data_o[63:0]=1 and [511:448]=8.
  - Exactly 8 requests are issued.
- Backpressure, low-dim, 4 items, data_ready_i held 0 for 10 cycles:
  - Output stays stable.
  - At most one extra item is fetched, then no mem_req_o.
  - After release, all 4 items arrive in order with no bubble between the 2nd and 3rd.
- num_items 0 → done_o at cycle 1, zero mem_req_o, busy_o low from cycle 2.
- clr_i in WAIT with rvalid arriving 2 cycles later:
  - The late word is discarded and data_valid_o stays 0.
  - Back to IDLE; a following start completes normally.
- rst_i mid-transfer (high-dim, word 4 of 8):
  - All outputs are 0 on the next cycle.
  - A restart reads from the new base; no stale bits appear in highdim_data_o.
